// File: rtl/osd_mam_wb_sram.sv
// Wishbone classic slave RAM window with a fixed number of wait states.
// Out-of-window accesses complete with err_o and never touch the array.
module osd_mam_wb_sram #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           MEM_SIZE_BYTES = 1024,
   parameter int unsigned           WAIT_STATES    = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic [2:0]              cti_i,
   input  logic [1:0]              bte_i,
   output logic                    ack_o,
   output logic                    err_o,
   output logic [DATA_WIDTH-1:0]   dat_o
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = MEM_SIZE_BYTES / BYTES;
   localparam int unsigned LSB   = $clog2(BYTES);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(MEM_SIZE_BYTES);
   localparam logic [3:0]          WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
   logic [BYTES-1:0]        sel_q, sel_d;
   logic                    rng_q, rng_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    req;
   logic [ADDR_WIDTH-1:0]   off;
   logic                    in_range;
   logic                    wr_en;
   logic                    unused_ok;

   assign req      = cyc_i & stb_i;
   assign off      = addr_i - BASE_ADDR;
   assign in_range = (addr_i >= BASE_ADDR) && ({1'b0, off} < SIZE_EXT);
   assign unused_ok = ^{cti_i, bte_i, off};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      wdat_d  = wdat_q;
      sel_d   = sel_q;
      rng_d   = rng_q;
      dat_d   = dat_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d   = we_i;
               idx_d  = off[LSB +: IDX_W];
               wdat_d = dat_i;
               sel_d  = sel_i;
               rng_d  = in_range;
               cnt_d  = WAIT_CNT;
               state_d = (WAIT_CNT != '0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Read data is captured on the edge entering RESP so it is stable for the whole response cycle.
      if (state_d == ST_RESP && state_q != ST_RESP && !we_d) begin
         dat_d = rng_d ? mem_q[idx_d] : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         rng_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         rng_q   <= rng_d;
         dat_q   <= dat_d;
      end
   end

   assign wr_en = (state_q == ST_RESP) && we_q && rng_q && !rst_i;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (sel_q[b]) mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
         end
      end
   end

   // Reset during RESP suppresses the response as well as the write.
   assign ack_o = (state_q == ST_RESP) &&  rng_q && !rst_i;
   assign err_o = (state_q == ST_RESP) && !rng_q && !rst_i;
   assign dat_o = dat_q;

endmodule

// File: tb/tb_osd_mam_wb_sram.sv
// Scoreboard bench: one instance with no wait states, one with three.
module tb_osd_mam_wb_sram;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc  [2];
   logic        stb  [2];
   logic        we_s [2];
   logic [31:0] adr  [2];
   logic [31:0] wdat [2];
   logic [3:0]  sel  [2];
   logic [2:0]  cti  [2];
   logic [1:0]  bte  [2];
   logic        ack  [2];
   logic        err  [2];
   logic [31:0] rdat [2];

   int unsigned cyc_n  = 0;
   int unsigned checks = 0;
   int unsigned passed = 0;

   typedef struct {
      bit          is_err;
      bit          is_rd;
      logic [31:0] data;
      int unsigned due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   osd_mam_wb_sram #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0),
      .MEM_SIZE_BYTES(1024), .WAIT_STATES(0)
   ) u_ws0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we_s[0]),
      .addr_i(adr[0]), .dat_i(wdat[0]), .sel_i(sel[0]), .cti_i(cti[0]), .bte_i(bte[0]),
      .ack_o(ack[0]), .err_o(err[0]), .dat_o(rdat[0])
   );

   osd_mam_wb_sram #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0),
      .MEM_SIZE_BYTES(1024), .WAIT_STATES(3)
   ) u_ws3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we_s[1]),
      .addr_i(adr[1]), .dat_i(wdat[1]), .sel_i(sel[1]), .cti_i(cti[1]), .bte_i(bte[1]),
      .ack_o(ack[1]), .err_o(err[1]), .dat_o(rdat[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
   endtask

   task automatic mon(input int d, input logic a, input logic e, input logic [31:0] dt);
      exp_t x;
      int   qs;
      if (a === 1'b1 || e === 1'b1) begin
         chk("ack_err_exclusive", 32'(a & e), 32'd0);
         qs = (d == 0) ? q0.size() : q1.size();
         if (qs == 0) begin
            checks++;
            $display("FAIL unexpected_resp inst %0d: got ack=%b err=%b expected none (cycle %0d)",
                     d, a, e, cyc_n);
         end else begin
            x = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("resp_kind_err", 32'(e), 32'(x.is_err));
            chk("latency_cycle", cyc_n, x.due);
            if (x.is_rd) chk("read_data", dt, x.data);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, ack[0], err[0], rdat[0]);
      mon(1, ack[1], err[1], rdat[1]);
   end

   // Entered at a posedge; leaves the request asserted and returns at the posedge ending RESP.
   task automatic xfer(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input bit exp_err, input logic [31:0] exp_rd);
      exp_t e;
      bit   seen;
      #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we_s[d] = we; adr[d] = a; wdat[d] = wd; sel[d] = s;
      cti[d] = 3'b010; bte[d] = 2'b00;
      e.is_err = exp_err;
      e.is_rd  = !we;
      e.data   = exp_err ? 32'h0 : exp_rd;
      e.due    = cyc_n + 1 + ((d == 0) ? 0 : 3);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ack[d] === 1'b1 || err[d] === 1'b1) seen = 1'b1;
      end
      chk("resp_seen", 32'(seen), 32'd1);
      @(posedge clk);
   endtask

   task automatic idle(input int d);
      #1;
      cyc[d] = 1'b0; stb[d] = 1'b0; we_s[d] = 1'b0;
      adr[d] = $urandom; wdat[d] = $urandom; sel[d] = 4'h0;
      @(posedge clk);
   endtask

   // Request visible for one cycle only, then dropped while the slave is waiting.
   task automatic abort_xfer(input int d, input logic [31:0] a, input logic [31:0] wd);
      #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we_s[d] = 1'b1; adr[d] = a; wdat[d] = wd; sel[d] = 4'hF;
      @(posedge clk);
      #1;
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we_s[d] = 1'b0; adr[d] = '0;
         wdat[d] = '0; sel[d] = '0; cti[d] = '0; bte[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ack_ws0", 32'(ack[0]), 32'd0);
      chk("rst_err_ws0", 32'(err[0]), 32'd0);
      chk("rst_dat_ws0", rdat[0], 32'h0);
      chk("rst_ack_ws3", 32'(ack[1]), 32'd0);
      chk("rst_err_ws3", 32'(err[1]), 32'd0);
      chk("rst_dat_ws3", rdat[1], 32'h0);
      @(posedge clk);

      // zero wait states: basic write/read, unaligned address, byte lanes
      xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0);
      idle(0);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF);
      xfer(0, 0, 32'h13, 32'h0, 4'hF, 0, 32'hDEADBEEF);
      idle(0);
      xfer(0, 1, 32'h40, 32'hAABBCCDD, 4'hF, 0, 32'h0);
      xfer(0, 1, 32'h40, 32'h00000011, 4'h1, 0, 32'h0);
      xfer(0, 0, 32'h40, 32'h0, 4'hF, 0, 32'hAABBCC11);
      xfer(0, 1, 32'h40, 32'hFFEEDDCC, 4'h6, 0, 32'h0);
      xfer(0, 0, 32'h40, 32'h0, 4'hF, 0, 32'hAAEEDD11);
      idle(0);

      // window edges: last word in range, first byte past the window
      xfer(0, 1, 32'h0, 32'h0BADF00D, 4'hF, 0, 32'h0);
      xfer(0, 1, 32'h3FC, 32'h13579BDF, 4'hF, 0, 32'h0);
      xfer(0, 0, 32'h3FC, 32'h0, 4'hF, 0, 32'h13579BDF);
      xfer(0, 0, 32'h400, 32'h0, 4'hF, 1, 32'h0);
      xfer(0, 1, 32'h400, 32'hCAFEF00D, 4'hF, 1, 32'h0);
      xfer(0, 0, 32'h0, 32'h0, 4'hF, 0, 32'h0BADF00D);
      idle(0);

      // sel=0 write acks but changes nothing
      xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 32'h0);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF);
      idle(0);

      // 4-beat burst with strobe held, then read back the same way
      for (int i = 0; i < 4; i++)
         xfer(0, 1, 32'h100 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, 0, 32'h0);
      for (int i = 0; i < 4; i++)
         xfer(0, 0, 32'h100 + 32'(4*i), 32'h0, 4'hF, 0, 32'hA0000000 + 32'(i));
      idle(0);

      // three wait states: preloaded read latency
      xfer(1, 1, 32'h80, 32'h12345678, 4'hF, 0, 32'h0);
      idle(1);
      repeat (2) @(posedge clk);
      xfer(1, 0, 32'h80, 32'h0, 4'hF, 0, 32'h12345678);
      idle(1);

      // abort in WAIT, then a new request right after
      xfer(1, 1, 32'h30, 32'h11111111, 4'hF, 0, 32'h0);
      idle(1);
      abort_xfer(1, 32'h30, 32'h99999999);
      xfer(1, 0, 32'h30, 32'h0, 4'hF, 0, 32'h11111111);
      idle(1);

      // reset while a write waits: write dropped, no response
      xfer(1, 1, 32'h20, 32'h22222222, 4'hF, 0, 32'h0);
      idle(1);
      #1;
      cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b1; adr[1] = 32'h20;
      wdat[1] = 32'h55555555; sel[1] = 4'hF;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      xfer(1, 0, 32'h20, 32'h0, 4'hF, 0, 32'h22222222);
      idle(1);

      for (int i = 0; i < 4; i++)
         xfer(1, 1, 32'h200 + 32'(4*i), 32'hB0000000 + 32'(i), 4'hF, 0, 32'h0);
      idle(1);
      for (int i = 0; i < 4; i++)
         xfer(1, 0, 32'h200 + 32'(4*i), 32'h0, 4'hF, 0, 32'hB0000000 + 32'(i));
      idle(1);

      repeat (10) @(posedge clk);
      chk("scoreboard_empty_ws0", 32'(q0.size()), 32'd0);
      chk("scoreboard_empty_ws3", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
